// File: rtl/projection_line_reader_pkg.sv
// Shared definitions for the projection line reader: sample/RAM geometry,
// FSM state encodings and the depth of the output skid FIFO.
package projection_line_reader_pkg;

  localparam int kFilteredDataLength = 16;
  localparam int kProjectionLineSize = 16;
  localparam int kSLength            = $clog2(kProjectionLineSize);
  localparam int kReaderFifoDepth    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

endpackage

// File: rtl/nabp_skid_fifo.sv
// Two-entry register FIFO carrying a (data, last) payload; absorbs the RAM read
// latency so the output stream can stall without losing or repeating samples.
module nabp_skid_fifo
  import projection_line_reader_pkg::*;
#(
  parameter int pDataLength = kFilteredDataLength
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [pDataLength-1:0] push_data,
  input  logic                   push_last,
  input  logic                   pop,
  output logic [pDataLength-1:0] head_data,
  output logic                   head_last,
  output logic [1:0]             count
);

  logic [pDataLength-1:0] data_mem [kReaderFifoDepth];
  logic                   last_mem [kReaderFifoDepth];
  logic                   wr_ptr;
  logic                   rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= push_data;
      last_mem[wr_ptr] <= push_last;
    end
  end

  assign head_data = data_mem[rd_ptr];
  assign head_last = last_mem[rd_ptr];

endmodule

// File: rtl/projection_line_reader.sv
// Read-side controller for the filtered projection line RAM: issues a contiguous
// run of reads and streams the samples out over valid/ready with full throughput.
module projection_line_reader
  import projection_line_reader_pkg::*;
#(
  parameter int pDataLength = kFilteredDataLength,
  parameter int pRAMSize    = kProjectionLineSize,
  parameter int pAddrLength = kSLength
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [pAddrLength-1:0] base_addr,
  input  logic [pAddrLength:0]   length,
  input  logic                   abort,
  output logic                   ram_we,
  output logic [pAddrLength-1:0] ram_addr,
  input  logic [pDataLength-1:0] ram_data_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [pDataLength-1:0] out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  reader_state_t          state;
  reader_state_t          next_state;
  logic [pAddrLength:0]   remaining;
  logic                   inflight;
  logic                   inflight_last;
  logic                   done_next;
  logic                   issue;
  logic                   last_issue;
  logic                   pop;
  logic                   accept_start;
  logic                   flush;
  logic [1:0]             fifo_count;
  logic [pDataLength-1:0] head_data;
  logic                   head_last;
  logic [2:0]             occupancy;
  logic [2:0]             limit;

  // Wraps at the true RAM depth, which need not be a power of two.
  function automatic logic [pAddrLength-1:0] wrap_incr(input logic [pAddrLength-1:0] a);
    return (a == pAddrLength'(pRAMSize - 1)) ? '0 : a + 1'b1;
  endfunction

  assign out_valid    = (fifo_count != 2'd0);
  assign pop          = out_valid & out_ready;
  assign occupancy    = {1'b0, fifo_count} + {2'b00, inflight};
  assign limit        = 3'(kReaderFifoDepth) + {2'b00, pop};
  assign last_issue   = (remaining == (pAddrLength+1)'(1));
  assign issue        = (state == ISSUE) && !abort && (occupancy < limit);
  assign accept_start = (state == IDLE) && start && !abort;
  assign flush        = abort && (state != IDLE);

  always_comb begin
    next_state = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (accept_start) begin
          if (length == '0) done_next = 1'b1;
          else              next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          next_state = IDLE;
          done_next  = 1'b1;
        end else if (issue && last_issue) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        // The tagged beat is the final word, so once it leaves the FIFO is empty
        // and nothing remains in flight.
        if (abort || (pop && head_last)) begin
          next_state = IDLE;
          done_next  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ram_addr      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= next_state;
      done          <= done_next;
      inflight      <= issue;
      inflight_last <= issue && last_issue;
      if (accept_start && (length != '0)) begin
        ram_addr  <= base_addr;
        remaining <= length;
      end else if (issue) begin
        ram_addr  <= wrap_incr(ram_addr);
        remaining <= remaining - 1'b1;
      end
    end
  end

  nabp_skid_fifo #(
    .pDataLength(pDataLength)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (inflight),
    .push_data(ram_data_out),
    .push_last(inflight_last),
    .pop      (pop),
    .head_data(head_data),
    .head_last(head_last),
    .count    (fifo_count)
  );

  assign ram_we   = 1'b0;
  assign busy     = (state != IDLE);
  assign out_data = out_valid ? head_data : '0;
  assign out_last = out_valid & head_last;

endmodule

// File: tb/tb_projection_line_reader.sv
// Bench for projection_line_reader: table-driven transfers and random runs checked
// against an arithmetic model of the RAM contents, plus abort/reset sequences.
module tb_projection_line_reader;

  localparam int RAM = 16;
  localparam int DW  = 16;
  localparam int AW  = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          abort;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_out;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] tb_mem [RAM];

  int tests = 0;
  int fails = 0;

  projection_line_reader #(
    .pDataLength(DW),
    .pRAMSize   (RAM),
    .pAddrLength(AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .abort       (abort),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_data_out(ram_data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model: data appears one cycle after the address.
  always @(posedge clk) ram_data_out <= tb_mem[ram_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int base;
    int len;
    int mode;
    int exp_done;
    int exp_first;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic pick(input int mode, input int cyc);
    logic [7:0] pat;
    pat = 8'b0110_1001;
    case (mode)
      0:       return 1'b1;
      1:       return pat[cyc % 8];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_xfer(input int base, input int len, input int mode,
                          input int exp_done, input int exp_first);
    logic [DW-1:0] exp_q [$];
    logic          exp_l [$];
    int            cyc, got, done_cyc, first_cyc, max_cnt;
    bit            busy_bad, hold_bad, prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(DW'(100 + ((base + i) % RAM)));
      exp_l.push_back(i == len - 1);
    end
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(base);
    length    = (AW+1)'(len);
    out_ready = pick(mode, 0);
    cyc = 0; got = 0; done_cyc = -1; first_cyc = -1; max_cnt = 0;
    busy_bad = 0; hold_bad = 0; prev_stall = 0; prev_data = '0; prev_last = 1'b0;
    while (cyc < 300 && done_cyc < 0) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      out_ready = pick(mode, cyc);
      #1;
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        hold_bad = 1;
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
      if (done === 1'b0 && busy !== (len != 0)) busy_bad = 1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          check("beat_data", out_data, exp_q.pop_front());
          check("beat_last", out_last, exp_l.pop_front());
        end
        got++;
      end
      if (done === 1'b1) done_cyc = cyc;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
    check("done_seen", done_cyc >= 0, 1);
    if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
    check("first_valid_cycle", first_cyc, exp_first);
    check("beat_count", got, len);
    check("stall_hold", hold_bad, 0);
    check("busy_during_run", busy_bad, 0);
    check("fifo_max_le_2", max_cnt <= 2, 1);
    check("ram_we_low", ram_we, 0);
    @(negedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("idle_not_busy", busy, 0);
  endtask

  initial begin
    vec_t vecs [$];
    int   got;
    int   bs, ln;

    for (int i = 0; i < RAM; i++) tb_mem[i] = DW'(i + 100);
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    base_addr = '0; length = '0;

    vecs.push_back('{base: 5,  len: 4,  mode: 0, exp_done: 7,  exp_first: 3});
    vecs.push_back('{base: 14, len: 4,  mode: 0, exp_done: 7,  exp_first: 3});
    vecs.push_back('{base: 0,  len: 8,  mode: 1, exp_done: -1, exp_first: 3});
    vecs.push_back('{base: 3,  len: 0,  mode: 0, exp_done: 1,  exp_first: -1});
    vecs.push_back('{base: 15, len: 1,  mode: 0, exp_done: 4,  exp_first: 3});
    vecs.push_back('{base: 0,  len: 16, mode: 0, exp_done: 19, exp_first: 3});
    vecs.push_back('{base: 9,  len: 16, mode: 2, exp_done: -1, exp_first: 3});

    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_last", out_last, 0);
    check("reset_out_data", out_data, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ram_addr", ram_addr, 0);
    check("reset_ram_we", ram_we, 0);
    reset = 1'b0;

    foreach (vecs[k])
      run_xfer(vecs[k].base, vecs[k].len, vecs[k].mode, vecs[k].exp_done, vecs[k].exp_first);

    for (int r = 0; r < 12; r++) begin
      bs = int'($urandom_range(0, RAM - 1));
      ln = int'($urandom_range(0, RAM));
      run_xfer(bs, ln, 2, -1, (ln == 0) ? -1 : 3);
    end

    // abort together with start in IDLE: nothing starts
    @(negedge clk);
    start = 1'b1; abort = 1'b1; base_addr = '0; length = 5'd4; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    #1;
    check("abort_start_busy", busy, 0);
    check("abort_start_done", done, 0);
    check("abort_start_valid", out_valid, 0);

    // abort after the third accepted beat of a 10-word run
    @(negedge clk);
    start = 1'b1; base_addr = '0; length = 5'd10; out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 50 && got < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        check("abort_run_data", out_data, 100 + got);
        got++;
      end
    end
    check("abort_run_three_beats", got, 3);
    @(negedge clk);
    abort = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("abort_valid_low", out_valid, 0);
    check("abort_done_pulse", done, 1);
    check("abort_idle", busy, 0);
    @(negedge clk);
    #1;
    check("abort_done_cleared", done, 0);
    check("abort_valid_stays_low", out_valid, 0);
    run_xfer(0, 2, 0, 5, 3);

    // reset mid-run with a read in flight and a sample queued
    @(negedge clk);
    start = 1'b1; base_addr = AW'(5); length = 5'd10; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_reset_inflight_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_last", out_last, 0);
    check("midreset_out_data", out_data, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_ram_addr", ram_addr, 0);
    check("midreset_ram_we", ram_we, 0);
    reset = 1'b0;
    run_xfer(5, 4, 0, 7, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
